seq_multiplier_param: RTL and testbench
=======================================

Name: seq_multiplier_param

Overview:
- Parametrised sequential shift-add multiplier, NB-bit operands, 2*NB-bit product.
- Signed or unsigned mode is selected per operation.
- Adds reset, an explicit busy/ready handshake, a one-cycle done pulse, and back-to-back operation.
- Drop-in arithmetic unit for datapaths needing a low-area multiply at one product bit per clock.

Parameters:
- NB, 32, operand width in bits; legal range 2..64.
- CW, $clog2(NB), width of the iteration counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- sgn  input  1  mode, sampled with start: 1 = two's-complement signed, 0 = unsigned.
- A  input  NB  multiplicand, sampled with start.
- B  input  NB  multiplier, sampled with start.
- Product  output  2*NB  registered result; holds its value until the next completion.
- ready  output  1  high when idle or done; a new start is accepted only then.
- done  output  1  one-cycle pulse; Product is valid and new in that cycle.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE, counter=0, Product=0, done=0, ready=1.
  - Internal operand and accumulator registers are cleared.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE. ready = (state != RUN).
- IDLE, or DONE, with start=1 at edge t0:
  - Latch A, B and sgn; clear the accumulator; counter=0; go to RUN.
  - done deasserts at t0.
- IDLE with start=0: stay in IDLE.
- RUN, one multiplier bit per edge, LSB first; counter indexes bit i:
  - Bits i < NB-1: if B[i]=1, add A (sign-extended if sgn=1, zero-extended if sgn=0) to the partial sum. Then shift right one position, arithmetic if sgn=1, logical if sgn=0.
  - Bit i = NB-1 with sgn=1: if B[NB-1]=1, SUBTRACT the sign-extended A, because the multiplier MSB carries weight -2^(NB-1).
  - Bit i = NB-1 with sgn=0: add as for the other bits.
  - The add is NB+1 bits wide so the carry/sign is not lost.
- Completion:
  - At the edge processing bit NB-1 (edge t0+NB), load Product with the full 2*NB-bit result.
  - Set done=1 and go to DONE.
  - Latency from the accepting edge to Product valid is exactly NB edges.
- DONE:
  - done=1 for exactly one cycle.
  - With no start, go to IDLE at the next edge and drop done; Product holds.
  - With start=1 in DONE, accept a new operation immediately (back-to-back, no idle cycle).
- start while in RUN is ignored: no restart and no effect on the result.
- Operands A, B and sgn may change or be X after the accepting edge; the result is unaffected.
- Arithmetic: exact 2*NB-bit product, no saturation, no overflow possible.
  - Signed: -2^(NB-1) × -2^(NB-1) = +2^(2NB-2), which fits.
- Product changes only at a completion edge or at reset.

Test Plan:
- NB=32, sgn=1, A=-3, B=5 -> after 32 edges done=1 for one cycle, Product=64'hFFFF_FFFF_FFFF_FFF1, ready=1.
- NB=32, sgn=0, A=B=32'hFFFF_FFFF -> Product=64'hFFFF_FFFE_0000_0001. The same operands with sgn=1 -> Product=64'h0000_0000_0000_0001.
- NB=32, sgn=1, A=B=32'h8000_0000 -> Product=64'h4000_0000_0000_0000. Then NB=8 instance, sgn=1, A=-128, B=127 -> Product=16'hC080.
- start pulsed with A=7, B=6, then start=1 again with A=9, B=9 at RUN cycle 10 -> ignored, Product=42 at t0+32. Then start asserted in the done cycle with A=2, B=3 -> accepted, Product=6 at the next completion, no idle cycle.
- Random 1000 ops each mode, operands driven X after acceptance -> Product equals the reference model ($signed or unsigned) at every done; done is never 2 cycles wide.
- rst asserted mid-RUN (cycle 15) asynchronously, off clock edge -> Product=0, ready=1, done=0 immediately; no done afterward. A new op after release (A=-1, B=-1, sgn=1) -> Product=1.

Source files
------------

// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first,
// with a per-operation signed/unsigned mode and a ready/done handshake.
module seq_multiplier_param #(
    parameter int NB = 32,
    parameter int CW = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sgn,
    input  logic [NB-1:0]   A,
    input  logic [NB-1:0]   B,
    output logic [2*NB-1:0] Product,
    output logic            ready,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(NB - 1);

    state_t          state_r;
    logic [NB:0]     acc_r;
    logic [NB-1:0]   a_r;
    logic [NB-1:0]   low_r;
    logic            sgn_r;
    logic [CW-1:0]   cnt_r;

    logic [NB:0]     a_ext_s;
    logic [NB:0]     sum_s;
    logic            last_s;

    // Partial-sum step; the multiplier MSB weighs -2^(NB-1) in signed mode.
    always_comb begin
        last_s  = (cnt_r == LAST_BIT);
        a_ext_s = {sgn_r & a_r[NB-1], a_r};
        sum_s   = acc_r;
        if (!low_r[0]) begin
            sum_s = acc_r;
        end else if (last_s && sgn_r) begin
            sum_s = acc_r - a_ext_s;
        end else begin
            sum_s = acc_r + a_ext_s;
        end
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {(NB+1){1'b0}};
            a_r     <= {NB{1'b0}};
            low_r   <= {NB{1'b0}};
            sgn_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            Product <= {(2*NB){1'b0}};
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        low_r   <= B;
                        sgn_r   <= sgn;
                        acc_r   <= {(NB+1){1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        ready   <= 1'b0;
                        state_r <= RUN;
                    end else begin
                        ready   <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // Sum bit 0 drops into the vacated top of the multiplier register.
                    acc_r <= {sgn_r & sum_s[NB], sum_s[NB:1]};
                    low_r <= {sum_s[0], low_r[NB-1:1]};
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        Product <= {sum_s, low_r[NB-1:1]};
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done    <= 1'b0;
                        ready   <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Scoreboard bench for seq_multiplier_param: 32-bit and 8-bit instances checked
// against an integer-arithmetic reference model.
module tb_seq_multiplier_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = 32'd0, b32 = 32'd0;
    logic [63:0] product32;
    logic        ready32, done32;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic [15:0] product8;
    logic        ready8, done8;

    typedef struct {
        logic [63:0] p;
        int          c;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seq_multiplier_param #(.NB(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sgn(sgn32), .A(a32), .B(b32),
        .Product(product32), .ready(ready32), .done(done32)
    );

    seq_multiplier_param #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .A(a8), .B(b8),
        .Product(product8), .ready(ready8), .done(done8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (s) return 64'(sa * sb);
        else   return 64'(ua * ub);
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, ua, ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = {24'd0, a};
        ub = {24'd0, b};
        if (s) return 16'(sa * sb);
        else   return 16'(ua * ub);
    endfunction

    task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(ready32 == 1'b1, "ready_timeout32", {63'd0, ready32}, 64'd1);
        if (ready32) begin
            start32 = 1'b1; sgn32 = s; a32 = a; b32 = b;
            @(posedge clk);
            #1;
            e.p = exp;
            e.c = cyc;
            q32.push_back(e);
            chk(ready32 == 1'b0, "accept32", {63'd0, ready32}, 64'd0);
            start32 = 1'b0; sgn32 = 1'bx; a32 = 'x; b32 = 'x;
        end
    endtask

    task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(ready8 == 1'b1, "ready_timeout8", {63'd0, ready8}, 64'd1);
        if (ready8) begin
            start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
            @(posedge clk);
            #1;
            e.p = {48'd0, exp};
            e.c = cyc;
            q8.push_back(e);
            chk(ready8 == 1'b0, "accept8", {63'd0, ready8}, 64'd0);
            start8 = 1'b0; sgn8 = 1'bx; a8 = 'x; b8 = 'x;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(q32.size() == 0 && q8.size() == 0, "drain", 64'(q32.size() + q8.size()), 64'd0);
    endtask

    // Monitor for the 32-bit instance: result, latency, pulse width and hold.
    initial begin
        logic [63:0] last;
        bit          prev;
        exp_t        e;
        last = 64'd0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 64'd0;
                prev = 1'b0;
            end else if (done32) begin
                chk(!prev, "done32_width", 64'd2, 64'd1);
                chk(ready32 == 1'b1, "ready_at_done32", {63'd0, ready32}, 64'd1);
                chk(q32.size() != 0, "unexpected_done32", product32, 64'd0);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk(product32 === e.p, "product32", product32, e.p);
                    chk(cyc == e.c + 32, "latency32", 64'(cyc - e.c), 64'd32);
                end
                last = product32;
                prev = 1'b1;
            end else begin
                chk(product32 === last, "hold32", product32, last);
                prev = 1'b0;
            end
        end
    end

    // Monitor for the 8-bit instance.
    initial begin
        logic [15:0] last;
        bit          prev;
        exp_t        e;
        last = 16'd0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 16'd0;
                prev = 1'b0;
            end else if (done8) begin
                chk(!prev, "done8_width", 64'd2, 64'd1);
                chk(q8.size() != 0, "unexpected_done8", {48'd0, product8}, 64'd0);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk({48'd0, product8} === e.p, "product8", {48'd0, product8}, e.p);
                    chk(cyc == e.c + 8, "latency8", 64'(cyc - e.c), 64'd8);
                end
                last = product8;
                prev = 1'b1;
            end else begin
                chk(product8 === last, "hold8", {48'd0, product8}, {48'd0, last});
                prev = 1'b0;
            end
        end
    end

    initial begin
        logic        s;
        logic [31:0] a, b;
        logic [7:0]  c, d;

        repeat (3) @(negedge clk);
        chk(product32 === 64'd0, "reset_product32", product32, 64'd0);
        chk(ready32 === 1'b1, "reset_ready32", {63'd0, ready32}, 64'd1);
        chk(done32 === 1'b0, "reset_done32", {63'd0, done32}, 64'd0);
        chk(ready8 === 1'b1, "reset_ready8", {63'd0, ready8}, 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue32(1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        issue32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        issue32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        issue32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        drain();

        issue8(1'b1, 8'h80, 8'h7F, 16'hC080);
        issue8(1'b1, 8'h80, 8'h80, 16'h4000);
        issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        for (int i = 0; i < 200; i++) begin
            s = i[0];
            c = 8'($urandom);
            d = 8'($urandom);
            issue8(s, c, d, ref8(s, c, d));
        end
        drain();

        // A start while busy must be ignored; a start in the done cycle is taken at once.
        issue32(1'b0, 32'd7, 32'd6, 64'd42);
        repeat (10) @(negedge clk);
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd9; b32 = 32'd9;
        @(negedge clk);
        start32 = 1'b0; a32 = 'x; b32 = 'x;
        issue32(1'b0, 32'd2, 32'd3, 64'd6);
        drain();

        for (int i = 0; i < 2000; i++) begin
            s = (i >= 1000);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 15) == 0) b = 32'h8000_0000;
            if ($urandom_range(0, 31) == 0) b = 32'hFFFF_FFFF;
            issue32(s, a, b, ref32(s, a, b));
            if (i % 97 == 0) drain();
        end
        drain();

        // Asynchronous reset in the middle of an operation.
        issue32(1'b1, 32'h1234_5678, 32'h7654_3210, ref32(1'b1, 32'h1234_5678, 32'h7654_3210));
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk(product32 === 64'd0, "rst_mid_product", product32, 64'd0);
        chk(ready32 === 1'b1, "rst_mid_ready", {63'd0, ready32}, 64'd1);
        chk(done32 === 1'b0, "rst_mid_done", {63'd0, done32}, 64'd0);
        q32.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
